// File: rtl/pdh_cmd_master.sv
// pdh_cmd_master: fabric-side initiator for the pdh_core GPIO command word.
// Takes a command on a valid/ready request port, presents cmd/data with strobe
// low, raises strobe, waits for the callback echo (or a fixed hold for
// non-echo commands), drops strobe and returns the callback plus a status.
// Optional feature: define PDH_CMD_MASTER_TIMEOUT_EN to bound the echo wait
// by TIMEOUT_CYCLES; without it the echo wait is unbounded.
//
// state  | meaning
// IDLE   | ready for a request, strobe low
// SETUP  | cmd/data presented with strobe low
// STROBE | strobe high, waiting for echo or hold time
// CLEAR  | strobe low, waiting for echo to clear or setup time
// RESP   | response valid, waiting for rsp_ready_i
module pdh_cmd_master #(
  parameter int          SETUP_CYCLES   = 4,
  parameter int          HOLD_CYCLES    = 4,
  parameter logic [15:0] ECHO_CMD_MASK  = 16'h0002,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_cmd_i,
  input  logic [25:0] req_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_cb_o,
  output logic [1:0]  rsp_status_o,
  input  logic        core_rst_i,
  output logic [31:0] gpio_to_core_o,
  input  logic [31:0] gpio_from_core_i,
  output logic        busy_o
);

  localparam int MAX_SH  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_SH > TIMEOUT_CYCLES) ? MAX_SH : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] SETUP_LOAD   = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_OK_ECHO   = 2'b00;
  localparam logic [1:0] ST_OK_NOECHO = 2'b01;
  localparam logic [1:0] ST_TIMEOUT   = 2'b10;
  localparam logic [1:0] ST_ABORTED   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_CLEAR  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          echo_q;
  logic          echo_seen;

  // The core reflects the latched command with its strobe echo bit set
  assign echo_seen = (gpio_from_core_i[31:28] == gpio_to_core_o[29:26]) && gpio_from_core_i[27];

  // Command sequencing FSM; every output is registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      echo_q         <= 1'b0;
      gpio_to_core_o <= '0;
      rsp_valid_o    <= 1'b0;
      rsp_cb_o       <= '0;
      rsp_status_o   <= ST_OK_ECHO;
      req_ready_o    <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      gpio_to_core_o[31] <= core_rst_i;
      if (core_rst_i && (state == S_SETUP || state == S_STROBE || state == S_CLEAR)) begin
        // Core being reset under us: abandon the command and report it
        gpio_to_core_o[30] <= 1'b0;
        rsp_cb_o           <= gpio_from_core_i;
        rsp_status_o       <= ST_ABORTED;
        rsp_valid_o        <= 1'b1;
        state              <= S_RESP;
      end else begin
        case (state)
          S_IDLE: begin
            if (req_valid_i && req_ready_o) begin
              gpio_to_core_o[30]    <= 1'b0;
              gpio_to_core_o[29:26] <= req_cmd_i;
              gpio_to_core_o[25:0]  <= req_data_i;
              echo_q                <= ECHO_CMD_MASK[req_cmd_i];
              cnt                   <= SETUP_LOAD;
              req_ready_o           <= 1'b0;
              busy_o                <= 1'b1;
              state                 <= S_SETUP;
            end else begin
              req_ready_o <= !core_rst_i;
            end
          end
          S_SETUP: begin
            if (cnt == '0) begin
              gpio_to_core_o[30] <= 1'b1;
              cnt                <= echo_q ? TIMEOUT_LOAD : HOLD_LOAD;
              state              <= S_STROBE;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_STROBE: begin
            if (echo_q) begin
              if (echo_seen) begin
                rsp_cb_o           <= gpio_from_core_i;
                gpio_to_core_o[30] <= 1'b0;
                cnt                <= TIMEOUT_LOAD;
                state              <= S_CLEAR;
              end
`ifdef PDH_CMD_MASTER_TIMEOUT_EN
              else if (cnt == '0) begin
                gpio_to_core_o[30] <= 1'b0;
                rsp_cb_o           <= gpio_from_core_i;
                rsp_status_o       <= ST_TIMEOUT;
                rsp_valid_o        <= 1'b1;
                state              <= S_RESP;
              end
`endif
              else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
              end
            end else if (cnt == '0) begin
              rsp_cb_o           <= gpio_from_core_i;
              gpio_to_core_o[30] <= 1'b0;
              cnt                <= SETUP_LOAD;
              state              <= S_CLEAR;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_CLEAR: begin
            if (echo_q) begin
              if (!gpio_from_core_i[27]) begin
                rsp_status_o <= ST_OK_ECHO;
                rsp_valid_o  <= 1'b1;
                state        <= S_RESP;
              end
`ifdef PDH_CMD_MASTER_TIMEOUT_EN
              else if (cnt == '0) begin
                rsp_cb_o     <= gpio_from_core_i;
                rsp_status_o <= ST_TIMEOUT;
                rsp_valid_o  <= 1'b1;
                state        <= S_RESP;
              end
`endif
              else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
              end
            end else if (cnt == '0) begin
              rsp_status_o <= ST_OK_NOECHO;
              rsp_valid_o  <= 1'b1;
              state        <= S_RESP;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_RESP: begin
            if (rsp_valid_o && rsp_ready_i) begin
              rsp_valid_o <= 1'b0;
              busy_o      <= 1'b0;
              req_ready_o <= !core_rst_i;
              state       <= S_IDLE;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
